// File: rtl/axi_err_pkg.sv
// Shared types and response codes for the AXI decode-error slave.
package axi_err_pkg;

  typedef enum logic [0:0] {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'b00,
    W_DATA = 2'b01,
    W_RESP = 2'b10
  } wr_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/axi_err_if.sv
// AXI channel bundle between an interconnect default port (master) and the error slave.
interface axi_err_if #(
  parameter int ID_W   = 8,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LEN_W  = 4
);
  logic [ID_W-1:0]     ARID;
  logic [ADDR_W-1:0]   ARADDR;
  logic [LEN_W-1:0]    ARLEN;
  logic [2:0]          ARSIZE;
  logic [1:0]          ARBURST;
  logic                ARVALID;
  logic                ARREADY;

  logic [ID_W-1:0]     RID;
  logic [DATA_W-1:0]   RDATA;
  logic [1:0]          RRESP;
  logic                RLAST;
  logic                RVALID;
  logic                RREADY;

  logic [ID_W-1:0]     AWID;
  logic [ADDR_W-1:0]   AWADDR;
  logic [LEN_W-1:0]    AWLEN;
  logic [2:0]          AWSIZE;
  logic [1:0]          AWBURST;
  logic                AWVALID;
  logic                AWREADY;

  logic [DATA_W-1:0]   WDATA;
  logic [DATA_W/8-1:0] WSTRB;
  logic                WLAST;
  logic                WVALID;
  logic                WREADY;

  logic [ID_W-1:0]     BID;
  logic [1:0]          BRESP;
  logic                BVALID;
  logic                BREADY;

  modport slave (
    input  ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    output ARREADY,
    output RID, RDATA, RRESP, RLAST, RVALID,
    input  RREADY,
    input  AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    output AWREADY,
    input  WDATA, WSTRB, WLAST, WVALID,
    output WREADY,
    output BID, BRESP, BVALID,
    input  BREADY
  );

  modport master (
    output ARID, ARADDR, ARLEN, ARSIZE, ARBURST, ARVALID,
    input  ARREADY,
    input  RID, RDATA, RRESP, RLAST, RVALID,
    output RREADY,
    output AWID, AWADDR, AWLEN, AWSIZE, AWBURST, AWVALID,
    input  AWREADY,
    output WDATA, WSTRB, WLAST, WVALID,
    input  WREADY,
    input  BID, BRESP, BVALID,
    output BREADY
  );
endinterface

// File: rtl/axi_err_log.sv
// Sticky first-fault capture plus saturating handshake counter for the error slave.
module axi_err_log #(
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              err_clr,
  input  logic              ar_hs,
  input  logic              aw_hs,
  input  logic [ADDR_W-1:0] ar_addr,
  input  logic [ADDR_W-1:0] aw_addr,
  input  logic              len_mis_set,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_is_wr,
  output logic              err_len_mis,
  output logic [CNT_W-1:0]  err_cnt
);
  localparam int SUM_W = CNT_W + 1;

  logic              valid_q, valid_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              is_wr_q, is_wr_d;
  logic              len_mis_q, len_mis_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [SUM_W-1:0]  cnt_sum;

  // Clear is applied first so a same-cycle handshake lands in the freshly emptied log.
  always_comb begin
    valid_d   = valid_q;
    addr_d    = addr_q;
    is_wr_d   = is_wr_q;
    len_mis_d = len_mis_q;
    cnt_d     = cnt_q;
    cnt_sum   = '0;
    if (err_clr) begin
      valid_d   = 1'b0;
      addr_d    = '0;
      is_wr_d   = 1'b0;
      len_mis_d = 1'b0;
      cnt_d     = '0;
    end
    if ((ar_hs || aw_hs) && !valid_d) begin
      valid_d = 1'b1;
      addr_d  = ar_hs ? ar_addr : aw_addr;
      is_wr_d = !ar_hs;
    end
    len_mis_d = len_mis_d | len_mis_set;
    cnt_sum   = {1'b0, cnt_d} + SUM_W'(ar_hs) + SUM_W'(aw_hs);
    cnt_d     = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      valid_q   <= 1'b0;
      addr_q    <= '0;
      is_wr_q   <= 1'b0;
      len_mis_q <= 1'b0;
      cnt_q     <= '0;
    end else begin
      valid_q   <= valid_d;
      addr_q    <= addr_d;
      is_wr_q   <= is_wr_d;
      len_mis_q <= len_mis_d;
      cnt_q     <= cnt_d;
    end
  end

  assign err_valid   = valid_q;
  assign err_addr    = addr_q;
  assign err_is_wr   = is_wr_q;
  assign err_len_mis = len_mis_q;
  assign err_cnt     = cnt_q;
endmodule

// File: rtl/axi_err_slave.sv
// AXI default-port slave: answers every read and write burst with a full-length error response.
module axi_err_slave
  import axi_err_pkg::*;
#(
  parameter int                ID_W     = 8,
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter int                LEN_W    = 4,
  parameter logic [1:0]        RESP     = RESP_DECERR,
  parameter logic [DATA_W-1:0] ERR_DATA = '0,
  parameter int                CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  axi_err_if.slave          axi,
  input  logic              err_clr,
  output logic              err_valid,
  output logic [ADDR_W-1:0] err_addr,
  output logic              err_is_wr,
  output logic              err_len_mis,
  output logic [CNT_W-1:0]  err_cnt
);
  rd_state_e         rstate_q;
  logic              arready_q;
  logic              rvalid_q;
  logic              rlast_q;
  logic [ID_W-1:0]   rid_q;
  logic [DATA_W-1:0] rdata_q;
  logic [LEN_W-1:0]  rlen_q;
  logic [LEN_W-1:0]  rcnt_q;

  wr_state_e         wstate_q;
  logic              awready_q;
  logic              wready_q;
  logic              bvalid_q;
  logic [ID_W-1:0]   bid_q;
  logic [LEN_W-1:0]  wlen_q;
  logic [LEN_W-1:0]  wcnt_q;

  logic ar_hs, aw_hs, w_hs, len_mis_set;
  logic unused_ok;

  assign ar_hs = axi.ARVALID && arready_q;
  assign aw_hs = axi.AWVALID && awready_q;
  assign w_hs  = axi.WVALID && wready_q;
  // A write beat disagrees with AWLEN when WLAST comes early or the final beat lacks WLAST.
  assign len_mis_set = w_hs && (axi.WLAST ? (wcnt_q != wlen_q) : (wcnt_q == wlen_q));
  assign unused_ok = ^{axi.ARSIZE, axi.ARBURST, axi.AWSIZE, axi.AWBURST, axi.WDATA, axi.WSTRB};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rstate_q  <= R_IDLE;
      arready_q <= 1'b1;
      rvalid_q  <= 1'b0;
      rlast_q   <= 1'b0;
      rid_q     <= '0;
      rdata_q   <= '0;
      rlen_q    <= '0;
      rcnt_q    <= '0;
    end else begin
      case (rstate_q)
        R_IDLE: if (axi.ARVALID) begin
          rstate_q  <= R_DATA;
          arready_q <= 1'b0;
          rvalid_q  <= 1'b1;
          rlast_q   <= (axi.ARLEN == '0);
          rid_q     <= axi.ARID;
          rdata_q   <= ERR_DATA;
          rlen_q    <= axi.ARLEN;
          rcnt_q    <= '0;
        end
        R_DATA: if (axi.RREADY) begin
          if (rlast_q) begin
            rstate_q  <= R_IDLE;
            arready_q <= 1'b1;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
          end else begin
            rcnt_q  <= rcnt_q + LEN_W'(1);
            rlast_q <= ((rcnt_q + LEN_W'(1)) == rlen_q);
          end
        end
        default: rstate_q <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wstate_q  <= W_IDLE;
      awready_q <= 1'b1;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bid_q     <= '0;
      wlen_q    <= '0;
      wcnt_q    <= '0;
    end else begin
      case (wstate_q)
        W_IDLE: if (axi.AWVALID) begin
          wstate_q  <= W_DATA;
          awready_q <= 1'b0;
          wready_q  <= 1'b1;
          bid_q     <= axi.AWID;
          wlen_q    <= axi.AWLEN;
          wcnt_q    <= '0;
        end
        W_DATA: if (axi.WVALID) begin
          if (axi.WLAST) begin
            wstate_q <= W_RESP;
            wready_q <= 1'b0;
            bvalid_q <= 1'b1;
          end else begin
            wcnt_q <= wcnt_q + LEN_W'(1);
          end
        end
        W_RESP: if (axi.BREADY) begin
          wstate_q  <= W_IDLE;
          awready_q <= 1'b1;
          bvalid_q  <= 1'b0;
        end
        default: wstate_q <= W_IDLE;
      endcase
    end
  end

  assign axi.ARREADY = arready_q;
  assign axi.RVALID  = rvalid_q;
  assign axi.RLAST   = rlast_q;
  assign axi.RID     = rid_q;
  assign axi.RDATA   = rdata_q;
  assign axi.RRESP   = RESP;
  assign axi.AWREADY = awready_q;
  assign axi.WREADY  = wready_q;
  assign axi.BVALID  = bvalid_q;
  assign axi.BID     = bid_q;
  assign axi.BRESP   = RESP;

  axi_err_log #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_log (
    .clk         (clk),
    .rst         (rst),
    .err_clr     (err_clr),
    .ar_hs       (ar_hs),
    .aw_hs       (aw_hs),
    .ar_addr     (axi.ARADDR),
    .aw_addr     (axi.AWADDR),
    .len_mis_set (len_mis_set),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_is_wr   (err_is_wr),
    .err_len_mis (err_len_mis),
    .err_cnt     (err_cnt)
  );
endmodule

// File: tb/tb_axi_err_slave.sv
// Directed bench for axi_err_slave: burst lengths, stalls, concurrency, log and reset behaviour.
module tb_axi_err_slave;
  logic        clk = 1'b0;
  logic        rst;
  logic        err_clr;
  logic        err_valid;
  logic [31:0] err_addr;
  logic        err_is_wr;
  logic        err_len_mis;
  logic [15:0] err_cnt;
  int          n_run = 0;
  int          n_fail = 0;

  axi_err_if #(.ID_W(8), .ADDR_W(32), .DATA_W(32), .LEN_W(4)) bus ();

  axi_err_slave dut (
    .clk         (clk),
    .rst         (rst),
    .axi         (bus.slave),
    .err_clr     (err_clr),
    .err_valid   (err_valid),
    .err_addr    (err_addr),
    .err_is_wr   (err_is_wr),
    .err_len_mis (err_len_mis),
    .err_cnt     (err_cnt)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.ARID = '0; bus.ARADDR = '0; bus.ARLEN = '0; bus.ARSIZE = 3'd2; bus.ARBURST = 2'b01; bus.ARVALID = 1'b0;
    bus.AWID = '0; bus.AWADDR = '0; bus.AWLEN = '0; bus.AWSIZE = 3'd2; bus.AWBURST = 2'b01; bus.AWVALID = 1'b0;
    bus.WDATA = 32'hDEAD_BEEF; bus.WSTRB = 4'hF; bus.WLAST = 1'b0; bus.WVALID = 1'b0;
    bus.RREADY = 1'b0; bus.BREADY = 1'b0; err_clr = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) cyc();
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1'b0;
    repeat (2) cyc();
    n_run++; if ({bus.ARREADY, bus.AWREADY} !== 2'b11) begin n_fail++; $display("FAIL rst_ready: got %b need 11", {bus.ARREADY, bus.AWREADY}); end
    n_run++; if ({bus.RVALID, bus.RLAST, bus.WREADY, bus.BVALID} !== 4'b0000) begin n_fail++; $display("FAIL rst_valids: got %b need 0000", {bus.RVALID, bus.RLAST, bus.WREADY, bus.BVALID}); end
    n_run++; if ({bus.RID, bus.BID, bus.RDATA} !== 48'h0) begin n_fail++; $display("FAIL rst_ids_data: got %h need 0", {bus.RID, bus.BID, bus.RDATA}); end
    n_run++; if ({bus.RRESP, bus.BRESP} !== 4'b1111) begin n_fail++; $display("FAIL rst_resp: got %b need 1111", {bus.RRESP, bus.BRESP}); end
    n_run++; if ({err_valid, err_is_wr, err_len_mis, err_addr, err_cnt} !== 51'h0) begin n_fail++; $display("FAIL rst_log: got %h need 0", {err_valid, err_is_wr, err_len_mis, err_addr, err_cnt}); end
    rst = 1'b1;
    cyc();
  endtask

  task automatic test_read_burst();
    do_reset();
    bus.ARID = 8'h05; bus.ARLEN = 4'd3; bus.ARADDR = 32'h0000_1000; bus.ARVALID = 1'b1; bus.RREADY = 1'b1;
    cyc();
    bus.ARVALID = 1'b0;
    n_run++; if (bus.ARREADY !== 1'b0) begin n_fail++; $display("FAIL rd_arready_busy: got %b need 0", bus.ARREADY); end
    for (int i = 0; i < 4; i++) begin
      n_run++;
      if ({bus.RVALID, bus.RID, bus.RRESP, bus.RDATA, bus.RLAST} !== {1'b1, 8'h05, 2'b11, 32'h0, (i == 3)}) begin
        n_fail++; $display("FAIL rd_beat%0d: got v=%b id=%h resp=%b data=%h last=%b need v=1 id=05 resp=11 data=0 last=%b",
                           i, bus.RVALID, bus.RID, bus.RRESP, bus.RDATA, bus.RLAST, (i == 3));
      end
      cyc();
    end
    n_run++; if ({bus.ARREADY, bus.RVALID} !== 2'b10) begin n_fail++; $display("FAIL rd_end: got arready,rvalid=%b need 10", {bus.ARREADY, bus.RVALID}); end
    n_run++; if ({err_valid, err_is_wr, err_addr, err_cnt} !== {1'b1, 1'b0, 32'h0000_1000, 16'd1}) begin
      n_fail++; $display("FAIL rd_log: got v=%b wr=%b addr=%h cnt=%0d need v=1 wr=0 addr=00001000 cnt=1", err_valid, err_is_wr, err_addr, err_cnt);
    end
  endtask

  task automatic test_read_stall();
    int beats = 0;
    logic r;
    do_reset();
    bus.ARID = 8'h21; bus.ARLEN = 4'd2; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0;
    for (int k = 0; k < 12 && beats < 3; k++) begin
      r = k[0];
      bus.RREADY = r;
      n_run++;
      if ({bus.RVALID, bus.RLAST} !== {1'b1, (beats == 2)}) begin
        n_fail++; $display("FAIL stall_k%0d: got v,last=%b need 1%b", k, {bus.RVALID, bus.RLAST}, (beats == 2));
      end
      cyc();
      if (r) beats++;
    end
    bus.RREADY = 1'b0;
    n_run++; if (beats != 3) begin n_fail++; $display("FAIL stall_beats: got %0d need 3", beats); end
    n_run++; if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin n_fail++; $display("FAIL stall_end: got rvalid,arready=%b need 01", {bus.RVALID, bus.ARREADY}); end
  endtask

  task automatic test_write();
    do_reset();
    bus.AWID = 8'h09; bus.AWLEN = 4'd1; bus.AWADDR = 32'h0000_2000; bus.AWVALID = 1'b1;
    cyc();
    bus.AWVALID = 1'b0;
    n_run++; if ({bus.WREADY, bus.AWREADY} !== 2'b10) begin n_fail++; $display("FAIL wr_wready: got wready,awready=%b need 10", {bus.WREADY, bus.AWREADY}); end
    bus.WVALID = 1'b1; bus.WLAST = 1'b0;
    cyc();
    n_run++; if ({bus.WREADY, bus.BVALID} !== 2'b10) begin n_fail++; $display("FAIL wr_mid: got wready,bvalid=%b need 10", {bus.WREADY, bus.BVALID}); end
    bus.WLAST = 1'b1;
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_run++;
      if ({bus.BVALID, bus.BID, bus.BRESP, bus.WREADY} !== {1'b1, 8'h09, 2'b11, 1'b0}) begin
        n_fail++; $display("FAIL wr_bhold%0d: got v=%b id=%h resp=%b wready=%b need v=1 id=09 resp=11 wready=0", i, bus.BVALID, bus.BID, bus.BRESP, bus.WREADY);
      end
      cyc();
    end
    bus.BREADY = 1'b1;
    cyc();
    bus.BREADY = 1'b0;
    n_run++; if ({bus.BVALID, bus.AWREADY} !== 2'b01) begin n_fail++; $display("FAIL wr_end: got bvalid,awready=%b need 01", {bus.BVALID, bus.AWREADY}); end
    n_run++; if ({err_valid, err_is_wr, err_len_mis, err_addr} !== {3'b110, 32'h0000_2000}) begin
      n_fail++; $display("FAIL wr_log: got v=%b wr=%b mis=%b addr=%h need v=1 wr=1 mis=0 addr=00002000", err_valid, err_is_wr, err_len_mis, err_addr);
    end
  endtask

  task automatic test_concurrent();
    do_reset();
    bus.ARID = 8'h01; bus.ARADDR = 32'h4000_0000; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
    bus.AWID = 8'h02; bus.AWADDR = 32'h5000_0000; bus.AWLEN = 4'd0; bus.AWVALID = 1'b1;
    bus.RREADY = 1'b1; bus.BREADY = 1'b1;
    cyc();
    bus.ARVALID = 1'b0; bus.AWVALID = 1'b0;
    n_run++; if ({err_valid, err_is_wr, err_addr, err_cnt} !== {1'b1, 1'b0, 32'h4000_0000, 16'd2}) begin
      n_fail++; $display("FAIL cc_log: got v=%b wr=%b addr=%h cnt=%0d need v=1 wr=0 addr=40000000 cnt=2", err_valid, err_is_wr, err_addr, err_cnt);
    end
    n_run++; if ({bus.RVALID, bus.RLAST, bus.RID, bus.WREADY} !== {2'b11, 8'h01, 1'b1}) begin
      n_fail++; $display("FAIL cc_first: got rv=%b rl=%b rid=%h wready=%b need 1 1 01 1", bus.RVALID, bus.RLAST, bus.RID, bus.WREADY);
    end
    bus.WVALID = 1'b1; bus.WLAST = 1'b1;
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n_run++; if ({bus.RVALID, bus.BVALID, bus.BID} !== {2'b01, 8'h02}) begin
      n_fail++; $display("FAIL cc_b: got rv=%b bv=%b bid=%h need 0 1 02", bus.RVALID, bus.BVALID, bus.BID);
    end
    cyc();
    n_run++; if ({bus.BVALID, bus.ARREADY, bus.AWREADY, err_len_mis} !== 4'b0110) begin
      n_fail++; $display("FAIL cc_end: got bv,arr,awr,mis=%b need 0110", {bus.BVALID, bus.ARREADY, bus.AWREADY, err_len_mis});
    end
    bus.RREADY = 1'b0; bus.BREADY = 1'b0;
  endtask

  task automatic test_len_mis();
    do_reset();
    bus.AWID = 8'h03; bus.AWLEN = 4'd3; bus.AWADDR = 32'h0000_3000; bus.AWVALID = 1'b1;
    cyc();
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WLAST = 1'b0;
    cyc();
    n_run++; if (err_len_mis !== 1'b0) begin n_fail++; $display("FAIL lm_early: got %b need 0", err_len_mis); end
    bus.WLAST = 1'b1;
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n_run++; if ({bus.BVALID, err_len_mis, err_cnt} !== {2'b11, 16'd1}) begin
      n_fail++; $display("FAIL lm_short: got bv=%b mis=%b cnt=%0d need 1 1 1", bus.BVALID, err_len_mis, err_cnt);
    end
    bus.BREADY = 1'b1;
    cyc();
    bus.BREADY = 1'b0;
    err_clr = 1'b1; bus.ARADDR = 32'h0000_6000; bus.ARID = 8'h44; bus.ARLEN = 4'd0; bus.ARVALID = 1'b1;
    cyc();
    err_clr = 1'b0; bus.ARVALID = 1'b0;
    n_run++; if ({err_valid, err_is_wr, err_len_mis, err_addr, err_cnt} !== {3'b100, 32'h0000_6000, 16'd1}) begin
      n_fail++; $display("FAIL lm_clr: got v=%b wr=%b mis=%b addr=%h cnt=%0d need v=1 wr=0 mis=0 addr=00006000 cnt=1",
                         err_valid, err_is_wr, err_len_mis, err_addr, err_cnt);
    end
    bus.RREADY = 1'b1;
    cyc();
    bus.RREADY = 1'b0;
    bus.AWID = 8'h0A; bus.AWLEN = 4'd0; bus.AWADDR = 32'h0000_7000; bus.AWVALID = 1'b1;
    cyc();
    bus.AWVALID = 1'b0;
    bus.WVALID = 1'b1; bus.WLAST = 1'b0;
    cyc();
    n_run++; if ({err_len_mis, bus.WREADY, bus.BVALID, err_cnt} !== {3'b110, 16'd2}) begin
      n_fail++; $display("FAIL lm_long: got mis=%b wready=%b bv=%b cnt=%0d need 1 1 0 2", err_len_mis, bus.WREADY, bus.BVALID, err_cnt);
    end
    bus.WLAST = 1'b1;
    cyc();
    bus.WVALID = 1'b0; bus.WLAST = 1'b0;
    n_run++; if ({bus.BVALID, bus.BID, err_addr} !== {1'b1, 8'h0A, 32'h0000_6000}) begin
      n_fail++; $display("FAIL lm_long_b: got bv=%b bid=%h addr=%h need 1 0a 00006000", bus.BVALID, bus.BID, err_addr);
    end
    bus.BREADY = 1'b1;
    cyc();
    bus.BREADY = 1'b0;
  endtask

  task automatic test_reset_mid();
    do_reset();
    bus.ARID = 8'h33; bus.ARLEN = 4'd3; bus.ARADDR = 32'h0000_8000; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0; bus.RREADY = 1'b1;
    cyc();
    rst = 1'b0;
    #1;
    n_run++; if ({bus.RVALID, bus.RLAST, bus.ARREADY, err_valid} !== 4'b0010) begin
      n_fail++; $display("FAIL rm_async: got rv,rl,arr,ev=%b need 0010", {bus.RVALID, bus.RLAST, bus.ARREADY, err_valid});
    end
    cyc();
    rst = 1'b1;
    cyc();
    n_run++; if ({bus.ARREADY, bus.RVALID} !== 2'b10) begin n_fail++; $display("FAIL rm_release: got arr,rv=%b need 10", {bus.ARREADY, bus.RVALID}); end
    bus.ARID = 8'h07; bus.ARLEN = 4'd1; bus.ARVALID = 1'b1;
    cyc();
    bus.ARVALID = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_run++;
      if ({bus.RVALID, bus.RID, bus.RLAST} !== {1'b1, 8'h07, (i == 1)}) begin
        n_fail++; $display("FAIL rm_beat%0d: got v=%b id=%h last=%b need 1 07 %b", i, bus.RVALID, bus.RID, bus.RLAST, (i == 1));
      end
      cyc();
    end
    n_run++; if ({bus.RVALID, bus.ARREADY} !== 2'b01) begin n_fail++; $display("FAIL rm_end: got rv,arr=%b need 01", {bus.RVALID, bus.ARREADY}); end
    bus.RREADY = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_read_burst();
    test_read_stall();
    test_write();
    test_concurrent();
    test_len_mis();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end
endmodule
